// File: rtl/capture_packer.sv
// Packs a qualified serial bit stream into WIDTH-bit words and queues them in a
// small circular FIFO; tracks capture-stage invalid events and FIFO overflow.
module capture_packer #(
  parameter int WIDTH = 8,
  parameter int ABITS = 2,
  parameter int CBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid_i,
  input  logic             bit_d_i,
  input  logic             locked_i,
  input  logic             invalid_i,
  output logic             ack_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             overflow_o,
  input  logic             clear_i,
  output logic [CBITS-1:0] err_count_o,
  output logic [ABITS:0]   level_o
);

  localparam int DEPTH = 1 << ABITS;
  localparam int CW    = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [ABITS:0]   FULL    = (ABITS + 1)'(DEPTH);
  localparam logic [CBITS-1:0] ERR_MAX = '1;

  logic [WIDTH-2:0]  sr_q, sr_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic              inv_q;
  logic [ABITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]    level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic [CBITS-1:0]  err_q, err_d, err_base;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [WIDTH-1:0]  word;
  logic              inv_rise, abort, take, complete, pop, push_ok, drop;

  assign word     = {sr_q, bit_d_i};
  assign inv_rise = invalid_i && !inv_q;
  assign abort    = !locked_i || inv_rise;
  assign take     = bit_valid_i && !abort;
  assign complete = take && (bcnt_q == LAST);
  assign pop      = out_valid_q && out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = complete && ((level_q != FULL) || pop);
  assign drop     = complete && !push_ok;

  always_comb begin
    sr_d   = sr_q;
    bcnt_d = bcnt_q;
    if (abort) begin
      sr_d   = '0;
      bcnt_d = '0;
    end else if (take) begin
      sr_d   = word[WIDTH-2:0];
      bcnt_d = complete ? '0 : bcnt_q + CW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ABITS'(push_ok);
    rd_ptr_d = rd_ptr_q + ABITS'(pop);
    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (ABITS + 1)'(1);
      2'b01:   level_d = level_q - (ABITS + 1)'(1);
      default: level_d = level_q;
    endcase
    out_valid_d = (level_d != '0);
  end

  // Set/increment wins over a simultaneous clear.
  always_comb begin
    overflow_d = drop ? 1'b1 : (clear_i ? 1'b0 : overflow_q);
    err_base   = clear_i ? '0 : err_q;
    err_d      = err_base;
    if (inv_rise && (err_base != ERR_MAX)) begin
      err_d = err_base + CBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      bcnt_q      <= '0;
      inv_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      inv_q       <= invalid_i;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= word;
    end
  end

  assign ack_o       = inv_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = mem[rd_ptr_q];
  assign overflow_o  = overflow_q;
  assign err_count_o = err_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_capture_packer.sv
// Scenario bench for capture_packer: expected words are queued as stimulus is
// driven and popped when the DUT presents them. Inputs change on the falling edge.
module tb_capture_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0, bit_d = 1'b0, locked = 1'b0, invalid = 1'b0;
  logic       out_ready = 1'b0, clear = 1'b0;
  logic       ack, out_valid, overflow;
  logic [7:0] out_data;
  logic [1:0] err_count;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  always #5 clk = ~clk;

  capture_packer #(.WIDTH(8), .ABITS(2), .CBITS(2)) dut (
    .clk(clk), .rst(rst),
    .bit_valid_i(bit_valid), .bit_d_i(bit_d), .locked_i(locked),
    .invalid_i(invalid), .ack_o(ack),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .overflow_o(overflow), .clear_i(clear),
    .err_count_o(err_count), .level_o(level)
  );

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b1;
    bit_d     = b;
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(w[i], (i == 0) ? 0 : gap);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    rst    = 1'b0;
    locked = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'b1011_0010;
    exp_q.push_back(w);
    send_word(w, 11);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d expected 1", level); end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (out_data !== exp) begin errors++; $display("FAIL basic_data: got %0h expected %0h", out_data, exp); end
    pop_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_word(8'(k), 1);
      if (k == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %0b expected 0", overflow); end
      end
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    for (int k = 0; k < 4; k++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL ovf_pop%0d: got v=%0b d=%0h expected v=1 d=%0h", k, out_valid, out_data, exp);
      end
      pop_one();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b expected 0", out_valid); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
  endtask

  task automatic test_lock_loss();
    send_bit(1'b1, 1); send_bit(1'b1, 1); send_bit(1'b0, 1);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL lock_level: got %0d expected 1", level); end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (out_data !== exp) begin errors++; $display("FAIL lock_data: got %0h expected %0h", out_data, exp); end
    pop_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_invalid();
    bit seen;
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1);
    invalid = 1'b1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL inv_ack_pre: got %0b expected 0", ack); end
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL inv_ack_rise: got %0b expected 1", ack); end
    checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL inv_err: got %0d expected 1", err_count); end
    seen = ack;
    for (int t = 0; t < 10 && !seen; t++) begin @(negedge clk); seen = ack; end
    checks++; if (!seen) begin errors++; $display("FAIL inv_ack_timeout: got 0 expected 1"); end
    @(negedge clk);
    invalid = 1'b0;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL inv_ack_held: got %0b expected 1", ack); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL inv_ack_fall: got %0b expected 0", ack); end
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 1);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL inv_level: got %0d expected 1", level); end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (out_data !== exp) begin errors++; $display("FAIL inv_data: got %0h expected %0h", out_data, exp); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h11 + 8'(k));
      send_word(8'h11 + 8'(k), 1);
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d expected 4", level); end
    for (int i = 7; i >= 1; i--) send_bit(1'((8'h5A >> i) & 8'h1), 1);
    bit_valid = 1'b1;
    bit_d     = 1'b0;
    out_ready = 1'b1;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (out_data !== exp) begin errors++; $display("FAIL b2b_head: got %0h expected %0h", out_data, exp); end
    @(negedge clk);
    bit_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(8'h5A);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level: got %0d expected 4", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %0b expected 0", overflow); end
    for (int k = 0; k < 4; k++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL b2b_pop%0d: got v=%0b d=%0h expected v=1 d=%0h", k, out_valid, out_data, exp);
      end
      pop_one();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_saturation_reset();
    for (int k = 0; k < 5; k++) begin
      invalid = 1'b1;
      @(negedge clk);
      invalid = 1'b0;
      repeat (2) @(negedge clk);
    end
    checks++; if (err_count !== 2'd3) begin errors++; $display("FAIL sat_err: got %0d expected 3", err_count); end
    clear   = 1'b1;
    invalid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL clear_vs_inc: got %0d expected 1", err_count); end
    invalid = 1'b0;
    repeat (2) @(negedge clk);
    send_word(8'h77, 1);
    send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
    invalid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL rst_err: got %0d expected 0", err_count); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %0b expected 0", ack); end
    rst     = 1'b0;
    invalid = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h81);
    send_word(8'h81, 1);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL rst_next_level: got %0d expected 1", level); end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (out_data !== exp) begin errors++; $display("FAIL rst_next_data: got %0h expected %0h", out_data, exp); end
    pop_one();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_lock_loss();
    test_invalid();
    test_back_to_back();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
